// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper
// Robot-side endpoint of the remote command link.
//   RX path: 2-flop synchronizer -> 8N1 receiver -> two-byte assembler that
//            produces a 16-bit command {high_byte, low_byte} plus cmd_rdy.
//   TX path: 8N1 transmitter for 8-bit response bytes (e.g. 0xA5 ack).
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   RX / TX          serial in (async, idle high) / serial out (idle high)
//   cmd, cmd_rdy     assembled command and its valid flag
//   clr_cmd_rdy      consumer acknowledge for cmd_rdy
//   resp, send_resp  response byte and one-cycle start strobe
//   resp_sent        one-cycle pulse after the stop bit completes
// Parameters: BAUD_DIV (clk cycles per bit), TMO_CYCLES (inter-byte timeout)
// Optional feature: define CMD_TIMEOUT_EN to drop a stale high byte after
// TMO_CYCLES without a validated low-byte start bit.
//
// rx_state  | meaning
// RX_IDLE   | waiting for a falling edge on the synchronized line
// RX_START  | half-bit wait, then re-check the start bit
// RX_DATA   | sampling 8 data bits, LSB first
// RX_STOP   | sampling the stop bit
//
// asm_state | meaning
// WAIT_HI   | next good byte is the high byte
// WAIT_LO   | high byte stored, next good byte completes cmd
//
// tx_state  | meaning
// TX_IDLE   | line high, waiting for send_resp
// TX_START  | driving the start bit
// TX_DATA   | driving 8 data bits, LSB first
// TX_STOP   | driving the stop bit, then pulse resp_sent

module uart_cmd_wrapper #(
    parameter int BAUD_DIV   = 5208,
    parameter int TMO_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam logic [15:0] BAUD_M1 = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {WAIT_HI, WAIT_LO} asm_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    rx_state_t  rx_state, rx_next;
    asm_state_t asm_state, asm_next;
    tx_state_t  tx_state, tx_next;

    logic        rx_s1, rx_s2, rx_s3;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bits;
    logic [7:0]  rx_shift;
    logic        rx_vld_q, rx_err_q;
    logic [7:0]  hi_byte;

    logic [15:0] tx_cnt;
    logic [2:0]  tx_bits;
    logic [7:0]  tx_shift;

    logic rx_fall, rx_tick, start_ok, byte_ok, frame_err, tx_tick, tmo_expire;

    // ---------------- RX synchronizer and receiver ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_fall   = rx_s3 & ~rx_s2;
    assign rx_tick   = (rx_cnt == 16'd0);
    assign start_ok  = (rx_state == RX_START) && rx_tick && !rx_s2;
    assign byte_ok   = (rx_state == RX_STOP) && rx_tick && rx_s2;
    assign frame_err = (rx_state == RX_STOP) && rx_tick && !rx_s2;

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bits == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= HALF_M1;
            rx_bits  <= 3'd0;
            rx_shift <= 8'd0;
            rx_vld_q <= 1'b0;
            rx_err_q <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rx_vld_q <= byte_ok;
            rx_err_q <= frame_err;
            if (rx_state == RX_IDLE) begin
                // Pre-load the half-bit delay so the start re-check lands mid-bit.
                rx_cnt <= HALF_M1;
            end else if (rx_tick) begin
                rx_cnt <= BAUD_M1;
                if (rx_state == RX_START) begin
                    rx_bits <= 3'd0;
                end else if (rx_state == RX_DATA) begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bits  <= rx_bits + 3'd1;
                end
            end else begin
                rx_cnt <= rx_cnt - 16'd1;
            end
        end
    end

    // ---------------- Command assembler ----------------
`ifdef CMD_TIMEOUT_EN
    localparam logic [19:0] TMO_M1 = 20'(TMO_CYCLES - 1);
    logic [19:0] tmo_cnt;
    logic        lo_seen;

    assign tmo_expire = (asm_state == WAIT_LO) && !lo_seen && !start_ok && (tmo_cnt == 20'd0);

    always_ff @(posedge clk) begin
        if (rst || asm_state != WAIT_LO) begin
            tmo_cnt <= TMO_M1;
            lo_seen <= 1'b0;
        end else if (start_ok) begin
            lo_seen <= 1'b1;
        end else if (!lo_seen && tmo_cnt != 20'd0) begin
            tmo_cnt <= tmo_cnt - 20'd1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^20'(TMO_CYCLES);
    assign tmo_expire = 1'b0;
`endif

    always_comb begin
        asm_next = asm_state;
        case (asm_state)
            WAIT_HI: if (rx_vld_q) asm_next = WAIT_LO;
            WAIT_LO: if (rx_vld_q || rx_err_q || tmo_expire) asm_next = WAIT_HI;
            default: asm_next = WAIT_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_state <= WAIT_HI;
            hi_byte   <= 8'd0;
            cmd       <= 16'd0;
            cmd_rdy   <= 1'b0;
        end else begin
            asm_state <= asm_next;
            if (asm_state == WAIT_HI && rx_vld_q)
                hi_byte <= rx_shift;
            // Set has priority over both clear sources.
            if (asm_state == WAIT_LO && rx_vld_q) begin
                cmd     <= {hi_byte, rx_shift};
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy || (start_ok && asm_state == WAIT_HI)) begin
                cmd_rdy <= 1'b0;
            end
        end
    end

    // ---------------- TX transmitter ----------------
    assign tx_tick = (tx_cnt == 16'd0);

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (send_resp) tx_next = TX_START;
            TX_START: if (tx_tick) tx_next = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bits == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= BAUD_M1;
            tx_bits   <= 3'd0;
            tx_shift  <= 8'd0;
            TX        <= 1'b1;
            resp_sent <= 1'b0;
        end else begin
            tx_state  <= tx_next;
            resp_sent <= 1'b0;
            if (tx_state == TX_IDLE) begin
                tx_cnt <= BAUD_M1;
                if (send_resp) begin
                    tx_shift <= resp;
                    TX       <= 1'b0;
                end
            end else if (tx_tick) begin
                tx_cnt <= BAUD_M1;
                case (tx_state)
                    TX_START: begin
                        TX       <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_bits  <= 3'd0;
                    end
                    TX_DATA: begin
                        // Seven more data bits follow d0; the eighth tick starts the stop bit.
                        TX       <= (tx_bits == 3'd7) ? 1'b1 : tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_bits  <= tx_bits + 3'd1;
                    end
                    default: resp_sent <= 1'b1;
                endcase
            end else begin
                tx_cnt <= tx_cnt - 16'd1;
            end
        end
    end

endmodule

// File: doc/uart_cmd_wrapper.md
Name: uart_cmd_wrapper

Overview:
Robot-side endpoint of the remote command link. It deserializes two UART bytes from the remote commander into one 16-bit command, high byte first, and flags it for the command processor. It also serializes 8-bit responses, such as the 0xA5 positive ack, back to the commander. It sits between the RX/TX pins and cmd_proc inside the KnightsTour top level.

Parameters:
BAUD_DIV, 5208, clk cycles per bit (50 MHz / 9600 baud); legal range 8..65535.
TMO_CYCLES, 1000000, max clk cycles allowed between the two command bytes (used only with CMD_TIMEOUT_EN).

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
RX  input  1  serial in from commander, asynchronous, idle high
TX  output  1  serial out to commander, idle high
cmd  output  16  assembled command {high_byte, low_byte}
cmd_rdy  output  1  complete command available
clr_cmd_rdy  input  1  consumer acknowledges cmd
resp  input  8  response byte to transmit
send_resp  input  1  one-cycle strobe to start transmitting resp
resp_sent  output  1  one-cycle pulse after the stop bit completes

Behaviour:
- Reset (synchronous, active-high) values: TX=1, cmd=0, cmd_rdy=0, resp_sent=0. The RX synchronizer presets to 1. All FSMs go to IDLE/WAIT_HI. Reset mid-frame aborts the frame with no partial outputs.
- RX path:
  - RX passes through a 2-flop synchronizer.
  - A start is a falling edge seen while the receiver is idle.
  - The start bit is re-checked at BAUD_DIV/2; if it is high, this is a false start and the receiver returns to idle.
  - Data bits are sampled every BAUD_DIV cycles after that, LSB first, 8 bits, followed by the stop bit.
  - If the stop bit samples 0 (framing error), the byte is discarded and the assembler returns to WAIT_HI.
- Assembler FSM:
  - WAIT_HI: a good byte is stored as the high byte; go to WAIT_LO.
  - WAIT_LO: a good byte sets cmd = {hi, byte}. cmd_rdy goes to 1 on the next clk, and the FSM returns to WAIT_HI.
  - cmd is not updated until the low byte is complete, so cmd stays stable while the next high byte arrives.
- cmd_rdy clears on clr_cmd_rdy.
- cmd_rdy also clears when the start bit of a new high byte is validated, because the old cmd is about to be superseded.
- If clr_cmd_rdy is asserted in the same cycle cmd_rdy is being set, the set wins.
- TX FSM has states IDLE, START, DATA, STOP:
  - send_resp in IDLE latches resp and starts transmission; TX goes low on the next clk.
  - Each bit is held for exactly BAUD_DIV cycles, LSB first; the stop bit is 1.
  - resp_sent pulses for one cycle on the clk after the stop bit ends, and the FSM returns to IDLE.
  - send_resp while the transmitter is not IDLE is ignored (no queue).
  - A send_resp arriving in the same cycle as resp_sent is accepted.
- Latencies:
  - cmd_rdy rises (9.5·BAUD_DIV + 3) ±1 clk after the falling edge of the low-byte start bit at the pin.
  - A frame takes 10·BAUD_DIV clks from send_resp to resp_sent.
- RX and TX run fully independently, so full-duplex operation is legal.
- Baud counters are 16-bit and count down. A counter reloads BAUD_DIV-1 when it reaches 0.

Optional Feature:
Macro: CMD_TIMEOUT_EN.
- Defined:
  - A 20-bit counter runs while the assembler is in WAIT_LO.
  - If TMO_CYCLES elapse without a validated low-byte start bit, the stored high byte is dropped and the assembler returns to WAIT_HI.
  - No output changes when this happens.
- Not defined:
  - There is no counter, and WAIT_LO waits indefinitely. Only a framing error or reset leaves WAIT_LO without receiving a low byte.

Test Plan:
- BAUD_DIV=16. Drive RX with bytes 0x4B then 0xF1 (8N1). Required: cmd=16'h4BF1, cmd_rdy=1 within 156±1 clk of the second start edge. clr_cmd_rdy=1 for one clk then gives cmd_rdy=0 with cmd held at 16'h4BF1.
- send_resp with resp=0xA5. Required: TX samples at bit centres 0,1,0,1,0,0,1,0,1,1, each bit 16 clks wide, then resp_sent pulses exactly once 160 clks after send_resp.
- Send 0x2A with the stop bit forced to 0, then send bytes 0x12 and 0x34. Required: cmd=16'h1234; the bad byte is not used as the high byte.
- 4-clk low glitch on RX. Required: no byte is received and the assembler stays in WAIT_HI. Then send 0x55,0xAA and require cmd=16'h55AA.
- A second send_resp (0x5A) issued during an ongoing 0xA5 transmission. Required: the TX waveform is 0xA5 only and resp_sent pulses once. A new send_resp on the resp_sent cycle starts 0x5A immediately.
- With CMD_TIMEOUT_EN and TMO_CYCLES=500: send 0x4B, idle 600 clks, then send 0x22 and 0x33. Required: cmd=16'h2233. Without the macro the same stimulus gives cmd=16'h4B22.
